// File: rtl/dino_game_sequencer.sv
// Game-flow controller for the Dino Run datapath: IDLE/RUN/HIT/OVER sequencing,
// motion tick, speed ramp, 5-digit BCD score and best score since reset.
module dino_game_sequencer #(
    parameter int TICK_CYCLES      = 2_000_000,
    parameter int SPEED_INIT       = 1,
    parameter int SPEED_MAX        = 8,
    parameter int PASSES_PER_LEVEL = 12,
    parameter int HIT_TICKS        = 25,
    parameter int REPLAY_LOCKOUT   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        collision,
    input  logic        obstacle_passed,
    output logic        tick,
    output logic [3:0]  speed,
    output logic [1:0]  anim_phase,
    output logic        running,
    output logic        game_over,
    output logic        clear_obstacles,
    output logic [19:0] score_bcd,
    output logic [19:0] hi_score_bcd
);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam int PW = (PASSES_PER_LEVEL > 1) ? $clog2(PASSES_PER_LEVEL) : 1;
    localparam int HW = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;
    localparam int LW = (REPLAY_LOCKOUT > 0) ? $clog2(REPLAY_LOCKOUT + 1) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [PW-1:0] PASS_LAST  = PW'(PASSES_PER_LEVEL - 1);
    localparam logic [HW-1:0] HIT_LAST   = HW'(HIT_TICKS - 1);
    localparam logic [LW-1:0] LOCK_FULL  = LW'(REPLAY_LOCKOUT);

    typedef enum logic [1:0] {IDLE, RUN, HIT, OVER} state_t;

    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [PW-1:0] pass_cnt_reg, pass_cnt_next;
    logic [HW-1:0] hit_cnt_reg, hit_cnt_next;
    logic [LW-1:0] lockout_reg, lockout_next;
    logic          start_q_reg;
    logic          tick_reg, tick_next;
    logic [3:0]    speed_reg, speed_next;
    logic [1:0]    anim_reg, anim_next;
    logic          running_reg, game_over_reg;
    logic          clear_reg, clear_next;
    logic [19:0]   score_reg, score_next;
    logic [19:0]   hi_reg, hi_next;

    logic          start_edge, pend, restart, hit_done;
    logic [5:0]    carry;
    logic [19:0]   score_inc;

    assign start_edge = start_btn & ~start_q_reg;
    assign pend       = (timer_reg == TIMER_LAST);
    assign restart    = start_edge &&
                        ((state_reg == IDLE) || (state_reg == OVER && lockout_reg == LOCK_FULL));
    assign hit_done   = (state_reg == HIT) && pend && (hit_cnt_reg == HIT_LAST);

    // Ripple BCD increment: a digit advances when every lower digit is 9; all-nines holds.
    assign carry[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_digit
            logic [3:0] digit;
            assign digit            = score_reg[gi*4 +: 4];
            assign carry[gi+1]      = carry[gi] && (digit == 4'd9);
            assign score_inc[gi*4 +: 4] = !carry[gi]      ? digit :
                                          (digit == 4'd9) ? 4'd0  : digit + 4'd1;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (restart)   state_next = RUN;
            RUN:     if (collision) state_next = HIT;
            HIT:     if (hit_done)  state_next = OVER;
            OVER:    if (restart)   state_next = RUN;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        timer_next    = pend ? '0 : timer_reg + 1'b1;
        tick_next     = (state_reg == RUN) && !collision && pend;
        clear_next    = restart;
        score_next    = score_reg;
        speed_next    = speed_reg;
        anim_next     = anim_reg;
        pass_cnt_next = pass_cnt_reg;
        hit_cnt_next  = hit_cnt_reg;
        lockout_next  = lockout_reg;
        hi_next       = hi_reg;
        if (restart) begin
            timer_next    = '0;
            score_next    = '0;
            speed_next    = 4'(SPEED_INIT);
            anim_next     = '0;
            pass_cnt_next = '0;
            hit_cnt_next  = '0;
            lockout_next  = '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (collision) begin
                        hit_cnt_next = '0;
                    end else begin
                        if (pend) begin
                            score_next = carry[5] ? score_reg : score_inc;
                            anim_next  = anim_reg + 2'd1;
                        end
                        if (obstacle_passed) begin
                            if (pass_cnt_reg == PASS_LAST) begin
                                pass_cnt_next = '0;
                                if (speed_reg < 4'(SPEED_MAX)) speed_next = speed_reg + 4'd1;
                            end else begin
                                pass_cnt_next = pass_cnt_reg + 1'b1;
                            end
                        end
                    end
                end
                HIT: begin
                    if (pend) hit_cnt_next = hit_cnt_reg + 1'b1;
                    if (hit_done && score_reg > hi_reg) hi_next = score_reg;
                end
                OVER: begin
                    if (pend && lockout_reg != LOCK_FULL) lockout_next = lockout_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_reg     <= '0;
            pass_cnt_reg  <= '0;
            hit_cnt_reg   <= '0;
            lockout_reg   <= '0;
            start_q_reg   <= 1'b0;
            tick_reg      <= 1'b0;
            speed_reg     <= 4'(SPEED_INIT);
            anim_reg      <= '0;
            running_reg   <= 1'b0;
            game_over_reg <= 1'b0;
            clear_reg     <= 1'b0;
            score_reg     <= '0;
            hi_reg        <= '0;
        end else begin
            timer_reg     <= timer_next;
            pass_cnt_reg  <= pass_cnt_next;
            hit_cnt_reg   <= hit_cnt_next;
            lockout_reg   <= lockout_next;
            start_q_reg   <= start_btn;
            tick_reg      <= tick_next;
            speed_reg     <= speed_next;
            anim_reg      <= anim_next;
            running_reg   <= (state_reg == RUN);
            game_over_reg <= (state_reg == OVER);
            clear_reg     <= clear_next;
            score_reg     <= score_next;
            hi_reg        <= hi_next;
        end
    end

    always_comb begin
        tick            = tick_reg;
        speed           = speed_reg;
        anim_phase      = anim_reg;
        running         = running_reg;
        game_over       = game_over_reg;
        clear_obstacles = clear_reg;
        score_bcd       = score_reg;
        hi_score_bcd    = hi_reg;
    end
endmodule
